// File: rtl/line_buf_sched.sv
// Line-buffer bank ring scheduler between the GBA capture side and the HDMI readout side.
// Optional feature: define LINESCHED_EDGE_REPL_EN to replicate the first/last line into the prev/next taps.

module line_buf_sched #(
   parameter int NUM_BANKS = 4,
   parameter int LINES     = 160
) (
   input  logic                         pxlClk,
   input  logic                         rst,
   input  logic                         newFrameIn,
   input  logic                         lineDoneIn,
   input  logic                         nextLine,
   output logic [$clog2(NUM_BANKS)-1:0] wrBank,
   output logic [$clog2(NUM_BANKS)-1:0] prevBank,
   output logic [$clog2(NUM_BANKS)-1:0] curBank,
   output logic [$clog2(NUM_BANKS)-1:0] nextBank,
   output logic                         sameLine,
   output logic [7:0]                   curLine,
   output logic                         resync,
   output logic                         frameDone,
   output logic                         overflow,
   output logic                         underrun
);

   localparam int         BW     = $clog2(NUM_BANKS);
   localparam logic [7:0] LAST   = 8'(LINES - 1);
   localparam logic [8:0] WR_MAX = 9'(LINES);
   localparam logic [8:0] LAG    = 9'(NUM_BANKS - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   state_t        state_q, state_n;
   logic [8:0]    wr_q, wr_n;
   logic [7:0]    rd_n;
   logic          ready, wr_block, ready_n;
   logic          same_n, resync_n, done_n, ovf_n, unr_n;
   logic [BW-1:0] wr_bank_n, cur_n, prev_n, next_n;

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_n  = state_q;
      wr_n     = wr_q;
      rd_n     = curLine;
      resync_n = 1'b0;
      done_n   = 1'b0;
      ovf_n    = overflow;
      unr_n    = underrun;

      // Both tests look at pre-update counters, so simultaneous write/read pulses see a consistent snapshot.
      ready    = ({1'b0, curLine} + 9'd2 <= wr_q) || (curLine == LAST);
      wr_block = (wr_q >= {1'b0, curLine} + LAG) || (wr_q == WR_MAX);

      if (newFrameIn) begin
         resync_n = (state_q == FILL) || (state_q == RUN);
         wr_n     = '0;
         rd_n     = '0;
         state_n  = FILL;
      end else begin
         if (lineDoneIn && state_q != IDLE) begin
            if (wr_block) ovf_n = 1'b1;
            else          wr_n  = wr_q + 9'd1;
         end
         case (state_q)
            FILL: if (wr_n >= 9'd2) state_n = RUN;
            RUN: begin
               if (nextLine) begin
                  if (!ready)              unr_n = 1'b1;
                  else if (curLine != LAST) rd_n  = curLine + 8'd1;
                  else begin
                     done_n  = 1'b1;
                     state_n = DONE;
                  end
               end
            end
            default: ;
         endcase
      end

      ready_n   = ({1'b0, rd_n} + 9'd2 <= wr_n) || (rd_n == LAST);
      same_n    = (state_n == RUN) ? !ready_n : 1'b1;
      wr_bank_n = wr_n[BW-1:0];
      cur_n     = rd_n[BW-1:0];
`ifdef LINESCHED_EDGE_REPL_EN
      prev_n    = (rd_n == 8'd0) ? cur_n : cur_n - BW'(1);
      next_n    = (rd_n == LAST) ? cur_n : cur_n + BW'(1);
`else
      prev_n    = cur_n - BW'(1);
      next_n    = cur_n + BW'(1);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_q      <= '0;
         curLine   <= '0;
         wrBank    <= '0;
         prevBank  <= '0;
         curBank   <= '0;
         nextBank  <= '0;
         sameLine  <= 1'b1;
         resync    <= 1'b0;
         frameDone <= 1'b0;
         overflow  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state_q   <= state_n;
         wr_q      <= wr_n;
         curLine   <= rd_n;
         sameLine  <= same_n;
         resync    <= resync_n;
         frameDone <= done_n;
         overflow  <= ovf_n;
         underrun  <= unr_n;
         // Banks keep their all-zero reset value until the first frame starts.
         if (state_n != IDLE) begin
            wrBank   <= wr_bank_n;
            prevBank <= prev_n;
            curBank  <= cur_n;
            nextBank <= next_n;
         end
      end
   end

endmodule

// File: tb/tb_line_buf_sched.sv
// Self-checking bench for line_buf_sched: a line-count model checked every cycle plus hand-computed pins.
// Honours LINESCHED_EDGE_REPL_EN the same way the design does.

module tb_line_buf_sched;

   localparam int N = 4;
   localparam int L = 160;
`ifdef LINESCHED_EDGE_REPL_EN
   localparam int EXP_PREV0   = 0;
   localparam int EXP_NEXT159 = 3;
`else
   localparam int EXP_PREV0   = 3;
   localparam int EXP_NEXT159 = 0;
`endif

   logic       pxlClk = 1'b0;
   logic       rst = 1'b1;
   logic       newFrameIn = 1'b0, lineDoneIn = 1'b0, nextLine = 1'b0;
   logic [1:0] wrBank, prevBank, curBank, nextBank;
   logic       sameLine, resync, frameDone, overflow, underrun;
   logic [7:0] curLine;

   line_buf_sched #(.NUM_BANKS(N), .LINES(L)) dut (
      .pxlClk(pxlClk), .rst(rst), .newFrameIn(newFrameIn), .lineDoneIn(lineDoneIn),
      .nextLine(nextLine), .wrBank(wrBank), .prevBank(prevBank), .curBank(curBank),
      .nextBank(nextBank), .sameLine(sameLine), .curLine(curLine), .resync(resync),
      .frameDone(frameDone), .overflow(overflow), .underrun(underrun)
   );

   always #5 pxlClk = ~pxlClk;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_count = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: lines written / line shown / phase (0 idle, 1 filling, 2 running, 3 done).
   int m_wr = 0, m_rd = 0, m_mode = 0;
   bit m_resync = 0, m_fd = 0, m_ovf = 0, m_unr = 0;

   function automatic bit m_ready(input int w, input int r);
      return (w >= r + 2) || (r == L - 1);
   endfunction

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_mode = 0;
      m_resync = 0; m_fd = 0; m_ovf = 0; m_unr = 0;
   endtask

   task automatic model_step(input bit nf, input bit ld, input bit nl);
      bit rdy, blk;
      rdy = m_ready(m_wr, m_rd);
      blk = (m_wr >= m_rd + N - 1) || (m_wr == L);
      m_resync = 0;
      m_fd     = 0;
      if (nf) begin
         m_resync = (m_mode == 1) || (m_mode == 2);
         m_wr = 0; m_rd = 0; m_mode = 1;
      end else begin
         if (ld && m_mode != 0) begin
            if (blk) m_ovf = 1;
            else     m_wr++;
         end
         if (nl && m_mode == 2) begin
            if (!rdy)            m_unr = 1;
            else if (m_rd < L-1) m_rd++;
            else begin
               m_fd = 1; m_mode = 3;
            end
         end
         if (m_mode == 1 && m_wr >= 2) m_mode = 2;
      end
   endtask

   function automatic int e_prev();
      if (m_mode == 0) return 0;
`ifdef LINESCHED_EDGE_REPL_EN
      if (m_rd == 0) return m_rd % N;
`endif
      return (m_rd + N - 1) % N;
   endfunction

   function automatic int e_next();
      if (m_mode == 0) return 0;
`ifdef LINESCHED_EDGE_REPL_EN
      if (m_rd == L - 1) return m_rd % N;
`endif
      return (m_rd + 1) % N;
   endfunction

   always @(negedge pxlClk) begin
      check("wrBank",    32'(wrBank),    (m_mode == 0) ? 0 : m_wr % N);
      check("curBank",   32'(curBank),   (m_mode == 0) ? 0 : m_rd % N);
      check("prevBank",  32'(prevBank),  e_prev());
      check("nextBank",  32'(nextBank),  e_next());
      check("curLine",   32'(curLine),   m_rd);
      check("sameLine",  32'(sameLine),  (m_mode == 2) ? int'(!m_ready(m_wr, m_rd)) : 1);
      check("resync",    32'(resync),    int'(m_resync));
      check("frameDone", 32'(frameDone), int'(m_fd));
      check("overflow",  32'(overflow),  int'(m_ovf));
      check("underrun",  32'(underrun),  int'(m_unr));
      if (frameDone === 1'b1) fd_count++;
   end

   task automatic cycle(input bit nf, input bit ld, input bit nl);
      newFrameIn = nf; lineDoneIn = ld; nextLine = nl;
      @(posedge pxlClk);
      if (rst) model_reset();
      else     model_step(nf, ld, nl);
      @(negedge pxlClk);
      #1;
      newFrameIn = 1'b0; lineDoneIn = 1'b0; nextLine = 1'b0;
   endtask

   initial begin
      // Reset, then pulses before any newFrameIn must not advance anything.
      repeat (3) cycle(0, 0, 0);
      check("rst_curLine", 32'(curLine), 0);
      check("rst_sameLine", 32'(sameLine), 1);
      check("rst_prevBank", 32'(prevBank), 0);
      rst = 1'b0;
      cycle(0, 1, 0); cycle(0, 0, 1); cycle(0, 1, 1);
      check("idle_wrBank", 32'(wrBank), 0);
      check("idle_overflow", 32'(overflow), 0);

      // Fill two lines and enter RUN.
      cycle(1, 0, 0);
      check("fill0_sameLine", 32'(sameLine), 1);
      cycle(0, 1, 0);
      check("fill1_sameLine", 32'(sameLine), 1);
      cycle(0, 1, 0);
      check("run_sameLine", 32'(sameLine), 0);
      check("run_curBank", 32'(curBank), 0);
      check("run_nextBank", 32'(nextBank), 1);
      check("run_wrBank", 32'(wrBank), 2);
      check("run_prevBank", 32'(prevBank), EXP_PREV0);

      // Full frame with the writer one line ahead.
      for (int i = 0; i < L - 1; i++) begin
         cycle(0, 0, 1);
         if (i < L - 2) cycle(0, 1, 0);
      end
      check("last_curLine", 32'(curLine), 159);
      check("last_nextBank", 32'(nextBank), EXP_NEXT159);
      check("last_fd_count", 32'(fd_count), 0);
      cycle(0, 0, 1);
      check("fd_pulse", 32'(frameDone), 1);
      check("fd_curLine", 32'(curLine), 159);
      cycle(0, 0, 1);
      check("fd_once", 32'(fd_count), 1);
      check("done_sameLine", 32'(sameLine), 1);
      check("frame_overflow", 32'(overflow), 0);
      check("frame_underrun", 32'(underrun), 0);

      // Underrun: reader catches the writer.
      cycle(1, 0, 0);
      check("restart_no_resync", 32'(resync), 0);
      cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 0, 1);
      cycle(0, 0, 1);
      check("unr_curLine", 32'(curLine), 1);
      check("unr_flag", 32'(underrun), 1);
      check("unr_sameLine", 32'(sameLine), 1);
      cycle(0, 1, 0);
      check("unr_sticky", 32'(underrun), 1);

      // Overflow: rdLine=5 allows wrLine up to 8.
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 1); cycle(0, 1, 0);
      end
      cycle(0, 1, 0);
      check("ovf_pre_wrBank", 32'(wrBank), 0);
      check("ovf_pre_flag", 32'(overflow), 0);
      cycle(0, 1, 0);
      check("ovf_wrBank", 32'(wrBank), 0);
      check("ovf_flag", 32'(overflow), 1);
      cycle(0, 1, 1);
      check("both_curLine", 32'(curLine), 6);
      check("both_wrBank", 32'(wrBank), 0);
      cycle(0, 1, 0);
      check("after_wrBank", 32'(wrBank), 1);

      // Only reset clears the sticky flags.
      rst = 1'b1;
      cycle(0, 0, 0);
      rst = 1'b0;
      check("clr_overflow", 32'(overflow), 0);
      check("clr_underrun", 32'(underrun), 0);

      // Resync at rdLine=40 with a simultaneous nextLine.
      cycle(1, 0, 0); cycle(0, 1, 0); cycle(0, 1, 0);
      for (int i = 0; i < 40; i++) begin
         cycle(0, 0, 1); cycle(0, 1, 0);
      end
      check("rs_pre_curLine", 32'(curLine), 40);
      cycle(1, 0, 1);
      check("rs_pulse", 32'(resync), 1);
      check("rs_curLine", 32'(curLine), 0);
      check("rs_sameLine", 32'(sameLine), 1);
      cycle(0, 0, 1);
      check("rs_pulse_end", 32'(resync), 0);
      check("rs_fill_hold", 32'(curLine), 0);

      // Asynchronous reset mid-frame.
      cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 0, 1);
      check("ar_pre_curLine", 32'(curLine), 1);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("ar_curLine", 32'(curLine), 0);
      check("ar_curBank", 32'(curBank), 0);
      check("ar_sameLine", 32'(sameLine), 1);
      cycle(0, 0, 0);
      rst = 1'b0;
      cycle(0, 1, 1); cycle(0, 1, 1);
      check("ar_hold_curLine", 32'(curLine), 0);
      check("ar_hold_wrBank", 32'(wrBank), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_buf_sched.md
LINE_BUF_SCHED -- requirements
Module: line_buf_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: line buffer banks in the ring, power of two, minimum 4.
REQ-002 SHALL have parameter LINES, default 160: GBA lines per frame.
REQ-003 SHALL have port pxlClk  in  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port newFrameIn  in  1  one-cycle pulse: the capture side starts frame line 0.
REQ-006 SHALL have port lineDoneIn  in  1  one-cycle pulse: the capture side finished writing the line in wrBank.
REQ-007 SHALL have port nextLine  in  1  one-cycle pulse: the HDMI side requests an advance to the next GBA line.
REQ-008 SHALL have port wrBank  out  log2(NUM_BANKS)  bank the capture side writes.
REQ-009 SHALL have ports prevBank, curBank, nextBank  out  log2(NUM_BANKS) each  banks feeding the previous/current/next-line pixel taps.
REQ-010 SHALL have port sameLine  out  1  next line is not ready; the HDMI side repeats the current line.
REQ-011 SHALL have port curLine  out  8  GBA line index being displayed, 0..LINES-1.
REQ-012 SHALL have port resync  out  1  one-cycle pulse when a frame restarts mid-frame.
REQ-013 SHALL have port frameDone  out  1  one-cycle pulse when the last line is consumed.
REQ-014 SHALL have ports overflow, underrun  out  1 each  sticky error flags.

Function
REQ-015 SHALL keep wrLine (lines completed this frame, 0..LINES) and rdLine (= curLine); line n lives in bank n mod NUM_BANKS.
REQ-016 SHALL drive wrBank = wrLine mod N, curBank = rdLine mod N, prevBank = (rdLine-1) mod N and nextBank = (rdLine+1) mod N, with N = NUM_BANKS; all outputs are registered.
REQ-017 SHALL run FSM states IDLE, FILL, RUN, DONE.
REQ-018 IDLE/DONE: on newFrameIn, SHALL clear wrLine and rdLine, then go to FILL.
REQ-019 FILL: when wrLine >= 2, SHALL go to RUN.
REQ-020 The next line is ready when wrLine >= rdLine+2, or when rdLine == LINES-1; in RUN, sameLine SHALL equal NOT ready; in IDLE, FILL and DONE, sameLine SHALL be 1.
REQ-021 RUN: nextLine while ready and rdLine < LINES-1 SHALL increment rdLine.
REQ-022 RUN: nextLine while not ready SHALL leave rdLine unchanged and set underrun.
REQ-023 RUN: nextLine at rdLine == LINES-1 SHALL pulse frameDone, go to DONE and keep rdLine.
REQ-024 lineDoneIn SHALL increment wrLine unless wrLine >= rdLine+N-1 or wrLine == LINES; in those cases it SHALL be dropped and overflow set. This protects the prev-line bank.
REQ-025 newFrameIn in FILL or RUN SHALL pulse resync, clear wrLine and rdLine, and go to FILL.
REQ-026 newFrameIn SHALL take priority over a simultaneous lineDoneIn or nextLine in the same cycle; both of those are discarded.
REQ-027 Simultaneous lineDoneIn and nextLine in RUN SHALL both apply, with readiness and overflow evaluated on pre-update values.
REQ-028 Index arithmetic SHALL be unsigned modulo N with no out-of-range bank values.
REQ-029 Outputs SHALL reflect an input pulse on the next rising edge, one cycle latency.

Reset
REQ-030 rst SHALL force state IDLE, wrLine=0, rdLine=0, all banks 0, sameLine=1, and resync, frameDone, overflow, underrun = 0.
REQ-031 rst asserted mid-frame SHALL abort immediately; after release, nothing advances until newFrameIn.
REQ-032 Sticky flags SHALL clear only on rst.

Configuration
REQ-033 Macro LINESCHED_EDGE_REPL_EN SHALL, when defined, force prevBank = curBank at rdLine == 0 and nextBank = curBank at rdLine == LINES-1.
REQ-034 When LINESCHED_EDGE_REPL_EN is undefined, SHALL use the plain ring formulas of REQ-016 at all lines.

Verification
REQ-035 Reset, newFrameIn, two lineDoneIn pulses -> FILL to RUN, sameLine=0, curBank=0, nextBank=1, wrBank=2.
REQ-036 Writer paced 1 line ahead for a full frame, 160 nextLine pulses -> curLine reaches 159, frameDone pulses once, state DONE, no flags set.
REQ-037 In RUN with wrLine=rdLine+1, send nextLine -> curLine unchanged, underrun=1, sameLine=1.
REQ-038 In RUN with rdLine=5, send lineDoneIn until wrLine=8 -> the next lineDoneIn is dropped, wrLine stays 8, overflow=1.
REQ-039 At rdLine=40, send newFrameIn together with nextLine -> resync pulse, curLine=0, state FILL, nextLine ignored.
REQ-040 LINESCHED_EDGE_REPL_EN on: rdLine=0 -> prevBank=0; rdLine=159 -> nextBank=3. Off: rdLine=0 -> prevBank=3.
